// File: rtl/gray_position_tracker_if.sv
// gray_position_tracker_if
//   Bundles the position-tracker signals between a Gray-code source and the
//   tracker.
//   master : drives gray_in and clr, observes the tracker outputs.
//   slave  : the tracker itself.
//   Signals:
//     gray_in    (WIDTH) Gray-coded position, asynchronous to clk
//     clr        (1)     synchronous clear of step_count and err_count
//     pos_bin    (WIDTH) registered decoded binary position
//     pos_valid  (1)     high once the first synchronised sample is loaded
//     step_up    (1)     one-cycle pulse, position +1
//     step_dn    (1)     one-cycle pulse, position -1
//     glitch     (1)     one-cycle pulse, illegal jump
//     step_count (CNT_W) signed accumulated steps, wraps
//     err_count  (ERR_W) saturating glitch count
//
// Handshake semantics: there is no valid/ready pair. gray_in is a level that
// is sampled on every rising clk edge. Outputs are qualified only by
// pos_valid. step_up, step_dn and glitch are single-cycle strobes that need no
// acknowledgement, and the consumer must never stall the tracker.
interface gray_position_tracker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
);
    logic [WIDTH-1:0] gray_in;
    logic             clr;
    logic [WIDTH-1:0] pos_bin;
    logic             pos_valid;
    logic             step_up;
    logic             step_dn;
    logic             glitch;
    logic [CNT_W-1:0] step_count;
    logic [ERR_W-1:0] err_count;

    modport master (
        output gray_in, clr,
        input  pos_bin, pos_valid, step_up, step_dn, glitch, step_count, err_count
    );

    modport slave (
        input  gray_in, clr,
        output pos_bin, pos_valid, step_up, step_dn, glitch, step_count, err_count
    );
endinterface

// File: rtl/gray_position_tracker.sv
// gray_position_tracker
//   Synchronises an asynchronous Gray-coded position word, decodes it to
//   binary and tracks the signed accumulated step count. Jumps of more than
//   one position are flagged as glitches and counted with saturation.
//   Ports:
//     clk       system clock, rising edge
//     rst_n     synchronous active-low reset
//     bus       gray_position_tracker_if.slave (gray_in/clr in, status out)
//     state_dbg current FSM state encoding (FILL=0, TRACK=1)
module gray_position_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gray_position_tracker_if.slave   bus,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        FILL  = 2'b00,
        TRACK = 2'b01
    } state_t;

    localparam logic [WIDTH-1:0] DIFF_UP = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DIFF_DN = {WIDTH{1'b1}};

    state_t           state_q, state_d;
    logic [1:0]       fill_cnt_q, fill_cnt_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] pos_bin_q, pos_bin_d;
    logic             pos_valid_q, pos_valid_d;
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] diff;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        decoded            = '0;
        decoded[WIDTH-1]   = sync2_q[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            decoded[i] = decoded[i+1] ^ sync2_q[i];
        end
    end

    // Modular difference, so 2^WIDTH-1 -> 0 reads as +1 and 0 -> 2^WIDTH-1 as -1.
    assign diff = decoded - pos_bin_q;

    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        sync1_d      = bus.gray_in;
        sync2_d      = sync1_q;
        pos_bin_d    = pos_bin_q;
        pos_valid_d  = pos_valid_q;
        step_up_d    = 1'b0;
        step_dn_d    = 1'b0;
        glitch_d     = 1'b0;
        step_count_d = step_count_q;
        err_count_d  = err_count_q;

        case (state_q)
            FILL: begin
                // Two edges fill sync1/sync2 with real samples; the third loads.
                if (fill_cnt_q == 2'd2) begin
                    pos_bin_d   = decoded;
                    pos_valid_d = 1'b1;
                    state_d     = TRACK;
                end else begin
                    fill_cnt_d = fill_cnt_q + 2'd1;
                end
            end
            TRACK: begin
                // Always follow the input, so a glitch resynchronises tracking.
                pos_bin_d = decoded;
                if (diff == DIFF_UP) begin
                    step_up_d    = 1'b1;
                    step_count_d = step_count_q + CNT_W'(1);
                end else if (diff == DIFF_DN) begin
                    step_dn_d    = 1'b1;
                    step_count_d = step_count_q - CNT_W'(1);
                end else if (diff != '0) begin
                    glitch_d = 1'b1;
                    if (err_count_q != {ERR_W{1'b1}}) begin
                        err_count_d = err_count_q + ERR_W'(1);
                    end
                end
            end
            default: begin
                state_d     = FILL;
                fill_cnt_d  = 2'd0;
                pos_valid_d = 1'b0;
            end
        endcase

        // Clear overrides any count update on the same edge; pulses are unaffected.
        if (bus.clr) begin
            step_count_d = '0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= FILL;
            fill_cnt_q   <= 2'd0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            pos_bin_q    <= '0;
            pos_valid_q  <= 1'b0;
            step_up_q    <= 1'b0;
            step_dn_q    <= 1'b0;
            glitch_q     <= 1'b0;
            step_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            pos_bin_q    <= pos_bin_d;
            pos_valid_q  <= pos_valid_d;
            step_up_q    <= step_up_d;
            step_dn_q    <= step_dn_d;
            glitch_q     <= glitch_d;
            step_count_q <= step_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.pos_bin    = pos_bin_q;
    assign bus.pos_valid  = pos_valid_q;
    assign bus.step_up    = step_up_q;
    assign bus.step_dn    = step_dn_q;
    assign bus.glitch     = glitch_q;
    assign bus.step_count = step_count_q;
    assign bus.err_count  = err_count_q;
    assign state_dbg      = state_q;

endmodule

// File: doc/gray_position_tracker.md
Name: gray_position_tracker

Overview:
Consumes Gray-coded position words, such as the output of the 4-bit binary-to-Gray stage or an absolute rotary encoder bus. It synchronises the asynchronous input, decodes it to binary and tracks the signed accumulated step count. Illegal multi-step jumps are flagged and counted. It sits directly downstream of the Gray encoder, feeding motor and position control logic.

Parameters:
WIDTH, 4, Gray/binary position word width (>=2)
CNT_W, 16, width of accumulated step counter (two's complement)
ERR_W, 8, width of saturating glitch counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
gray_in  input  WIDTH  Gray-coded position, asynchronous to clk
clr  input  1  synchronous clear of step_count and err_count
pos_bin  output  WIDTH  decoded binary position (registered)
pos_valid  output  1  high once first synchronised sample is loaded
step_up  output  1  one-cycle pulse, position advanced by +1
step_dn  output  1  one-cycle pulse, position retreated by -1
glitch  output  1  one-cycle pulse, illegal jump detected
step_count  output  CNT_W  signed accumulated steps, wraps modulo 2^CNT_W
err_count  output  ERR_W  number of glitches, saturates at all-ones

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled on clk rising edge). All outputs 0, sync regs 0, state FILL, fill counter 0. Reset asserted mid-operation aborts tracking immediately and refill restarts after release.
- Sync: gray_in -> sync1 -> sync2, a two-flop synchroniser.
- Decode (comb, on sync2): b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i].
- State FILL: stays for 2 edges after reset release so both sync stages hold real samples. No pulses; pos_valid=0.
- Transition FILL->TRACK, on 3rd edge with rst_n high: pos_bin<=decoded, pos_valid<=1. No step or glitch on this load.
- State TRACK, evaluated every edge: diff = (decoded - pos_bin) mod 2^WIDTH.
  - diff==0: no pulse.
  - diff==1: step_up=1, step_count+1.
  - diff==2^WIDTH-1: step_dn=1, step_count-1.
  - otherwise: glitch=1, err_count+1 (saturating), step_count unchanged.
  - pos_bin<=decoded in all cases; after a glitch, tracking resyncs to the new value.
- Latency: a gray_in value sampled at edge k appears in pos_bin, pulses and counters after edge k+2.
- Pulses are registered, exactly one cycle wide, mutually exclusive.
- Wrap-around: 2^WIDTH-1 -> 0 is step_up; 0 -> 2^WIDTH-1 is step_dn. step_count wraps as two's complement (0 minus 1 = all-ones). err_count holds at max.
- clr: step_count<=0, err_count<=0, and clr wins over a simultaneous step or glitch. Pulses and pos_bin still update normally on the same edge.
- No states besides FILL and TRACK; unreachable encodings return to FILL.

Test Plan:
- Load: WIDTH=4, reset, hold gray_in=4'b0110 -> pos_valid=0 for first 2 edges. After 3rd edge, pos_valid=1, pos_bin=4, step_count=0, no pulses.
- Forward and back: from pos 4, gray_in=4'b0111 -> after 2 edges step_up pulse (1 cycle), pos_bin=5, step_count=1. Then 4'b0110 -> step_dn, pos_bin=4, step_count=0.
- Wrap: pos 15 (4'b1000) -> 4'b0000 gives step_up, pos_bin=0. Back to 4'b1000 gives step_dn, pos_bin=15. Then step_dn again from count 0 -> step_count=16'hFFFF.
- Glitch: pos 4 (4'b0110) -> 4'b1101 gives glitch pulse, pos_bin=9, err_count=1, step_count unchanged. 256 glitches -> err_count=8'hFF, held.
- clr collision: clr=1 on the edge a step_up is taken -> step_count=0, err_count=0, step_up pulse still seen, pos_bin updated.
- Reset mid-run: step_count=5, assert rst_n=0 for 1 edge -> all outputs 0, pos_valid=0. Release -> pos_valid returns after 3 edges with no spurious pulse.
